// File: rtl/mem_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_fetch_unit
//  Purpose  : Multicycle MIPS front end. Owns PC, IR and MDR, runs a
//             request/ready handshake to a variable-latency unified memory
//             and stalls the control FSM until each access completes.
//  Options  : MEM_TIMEOUT_EN - builds a WAIT-state watchdog that sets the
//             sticky mem_err flag and abandons the access after
//             TIMEOUT_CYCLES cycles without mem_ready.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iord,
  input  logic        irwrite,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        pcwrite,
  input  logic        branch,
  input  logic        zero,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] aluresult,
  input  logic [31:0] aluout,
  input  logic [31:0] wdata_in,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] mdr,
  output logic        stall,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Which register a completing access lands in; write lands nowhere.
  localparam logic [1:0] KIND_IR  = 2'd0;
  localparam logic [1:0] KIND_MDR = 2'd1;
  localparam logic [1:0] KIND_WR  = 2'd2;

  state_t      state_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  kind_q;
  logic [31:0] instr_q;
  logic [31:0] mdr_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;

  logic        w_acc;
  logic [1:0]  w_kind;
  logic        w_pcen;
  logic        w_timeout;

  assign w_acc  = irwrite | memread | memwrite;
  // Write wins over both reads, fetch wins over data read.
  assign w_kind = memwrite ? KIND_WR : (irwrite ? KIND_IR : KIND_MDR);

  // Stall covers the issuing IDLE cycle and every WAIT cycle.
  assign stall  = ((state_q == ST_IDLE) & w_acc) | (state_q == ST_WAIT);

  // pcsrc=11 is "hold": the enable is suppressed rather than reloading pc.
  assign w_pcen = ~stall & (pcwrite | (branch & zero)) & (pcsrc != 2'b11);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Fires on the last allowed WAIT cycle when memory still has not answered.
  assign w_timeout = (state_q == ST_WAIT) & ~mem_ready &
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count idle WAIT cycles; outside WAIT the count sits at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q != ST_WAIT) begin
      cnt_q <= '0;
    end else if (!mem_ready) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Sticky error: only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (w_timeout) begin
      err_q <= 1'b1;
    end
  end

  assign mem_err = err_q;
`else
  assign w_timeout = 1'b0;
  assign mem_err   = 1'b0;
`endif

  // Access FSM: issue in IDLE, hold the bus in WAIT, release in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      kind_q  <= KIND_IR;
      instr_q <= 32'h0;
      mdr_q   <= 32'h0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (w_acc) begin
            req_q   <= 1'b1;
            addr_q  <= iord ? aluout : pc_q;
            we_q    <= memwrite;
            wdata_q <= wdata_in;
            kind_q  <= w_kind;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_ready) begin
            if (kind_q == KIND_IR) begin
              instr_q <= mem_rdata;
            end else if (kind_q == KIND_MDR) begin
              mdr_q <= mem_rdata;
            end
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= ST_DONE;
          end else if (w_timeout) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Next-PC selection; 11 is never used because pcen is blocked for it.
  always_comb begin
    pc_d = pc_q;
    unique case (pcsrc)
      2'b00:   pc_d = aluresult;
      2'b01:   pc_d = aluout;
      2'b10:   pc_d = {pc_q[31:28], instr_q[25:0], 2'b00};
      default: pc_d = pc_q;
    endcase
  end

  // PC register; during a fetch it only moves in DONE, after IR is loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (w_pcen) begin
      pc_q <= pc_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign mdr       = mdr_q;
  assign op        = instr_q[31:26];
  assign funct     = instr_q[5:0];

endmodule
`default_nettype wire

// File: tb/tb_mem_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_fetch_unit
//  Purpose  : Self-checking bench for mem_fetch_unit. Each memory access
//             pushes its expected outcome to a scoreboard; the entry is
//             popped and compared when the unit reaches DONE.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TO     = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        iord, irwrite, memread, memwrite, pcwrite, branch, zero;
  logic [1:0]  pcsrc;
  logic [31:0] aluresult, aluout, wdata_in, mem_rdata;
  logic        mem_ready;
  logic        mem_req, mem_we, stall, mem_err;
  logic [31:0] mem_addr, mem_wdata, pc, instr, mdr;
  logic [5:0]  op, funct;

  always #5 clk = ~clk;

  mem_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .iord(iord), .irwrite(irwrite),
    .memread(memread), .memwrite(memwrite), .pcwrite(pcwrite),
    .branch(branch), .zero(zero), .pcsrc(pcsrc), .aluresult(aluresult),
    .aluout(aluout), .wdata_in(wdata_in), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pc(pc), .instr(instr),
    .op(op), .funct(funct), .mdr(mdr), .stall(stall), .mem_err(mem_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr, we, wdata, instr, mdr, err, pc_done, pc_after;
    int          nstall;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc, m_instr, m_mdr, m_err;

  function automatic logic [31:0] next_pc(input logic pw, input logic br, input logic z,
                                          input logic [1:0] src, input logic [31:0] ares,
                                          input logic [31:0] aout, input logic [31:0] cur,
                                          input logic [31:0] ir);
    logic [31:0] r;
    r = cur;
    if ((pw || (br && z)) && src != 2'b11) begin
      if (src == 2'b00)      r = ares;
      else if (src == 2'b01) r = aout;
      else                   r = {cur[31:28], ir[25:0], 2'b00};
    end
    return r;
  endfunction

  task automatic clear_ctrl();
    iord = 0; irwrite = 0; memread = 0; memwrite = 0; pcwrite = 0;
    branch = 0; zero = 0; pcsrc = 2'b00; mem_ready = 0;
  endtask

  // delay = WAIT cycle carrying mem_ready (1 = first); 0 = never ready.
  task automatic do_access(input logic a_iord, input logic a_ir, input logic a_mr,
                           input logic a_mw, input logic a_pcw, input logic [31:0] a_aluout,
                           input logic [31:0] a_ares, input logic [31:0] a_wdata,
                           input logic [31:0] a_rdata, input int delay);
    exp_t e;
    exp_t g;
    int   n;
    bit   done;
    e.addr   = a_iord ? a_aluout : m_pc;
    e.we     = {31'b0, a_mw};
    e.wdata  = a_wdata;
    e.nstall = (delay == 0) ? 1 + TO : 1 + delay;
    if (delay == 0)  m_err = 32'd1;
    else if (a_mw)   ;
    else if (a_ir)   m_instr = a_rdata;
    else if (a_mr)   m_mdr   = a_rdata;
    e.instr   = m_instr;
    e.mdr     = m_mdr;
    e.err     = m_err;
    e.pc_done = m_pc;
    m_pc      = next_pc(a_pcw, 1'b0, 1'b0, 2'b00, a_ares, a_aluout, m_pc, m_instr);
    e.pc_after = m_pc;
    sb.push_back(e);

    @(posedge clk); #1;
    clear_ctrl();
    iord = a_iord; irwrite = a_ir; memread = a_mr; memwrite = a_mw; pcwrite = a_pcw;
    aluout = a_aluout; aluresult = a_ares; wdata_in = a_wdata; mem_rdata = a_rdata;
    n = 0;
    done = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      #4;
      if (!stall) begin
        done = 1;
      end else begin
        n++;
        if (n >= 2) begin
          check("wait_req",   32'(mem_req), 32'd1);
          check("wait_addr",  mem_addr,     sb[0].addr);
          check("wait_we",    32'(mem_we),  sb[0].we);
          check("wait_wdata", mem_wdata,    sb[0].wdata);
          check("wait_pc",    pc,           sb[0].pc_done);
        end
        @(posedge clk); #1;
        mem_ready = (delay != 0) && (n == delay);
      end
    end
    mem_ready = 0;
    g = sb.pop_front();
    if (!done) begin
      check("access_bound", 32'd0, 32'd1);
    end else begin
      check("stall_cycles", 32'(n),       32'(g.nstall));
      check("done_req",     32'(mem_req), 32'd0);
      check("done_we",      32'(mem_we),  32'd0);
      check("done_addr",    mem_addr,     g.addr);
      check("done_instr",   instr,        g.instr);
      check("done_op",      32'(op),      32'(g.instr[31:26]));
      check("done_funct",   32'(funct),   32'(g.instr[5:0]));
      check("done_mdr",     mdr,          g.mdr);
      check("done_err",     32'(mem_err), g.err);
      check("done_pc",      pc,           g.pc_done);
    end
    @(posedge clk); #1;
    clear_ctrl();
    check("pc_after", pc, g.pc_after);
  endtask

  task automatic pc_step(input logic pw, input logic br, input logic z, input logic [1:0] src,
                         input logic [31:0] ares, input logic [31:0] aout);
    @(posedge clk); #1;
    clear_ctrl();
    pcwrite = pw; branch = br; zero = z; pcsrc = src; aluresult = ares; aluout = aout;
    m_pc = next_pc(pw, br, z, src, ares, aout, m_pc, m_instr);
    #4;
    check("nacc_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    clear_ctrl();
    check("nacc_pc", pc, m_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    clear_ctrl();
    aluresult = 0; aluout = 0; wdata_in = 0; mem_rdata = 0;
    m_pc = RST_PC; m_instr = 0; m_mdr = 0; m_err = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",   32'(mem_req), 32'd0);
    check("rst_we",    32'(mem_we),  32'd0);
    check("rst_addr",  mem_addr,     32'd0);
    check("rst_wdata", mem_wdata,    32'd0);
    check("rst_pc",    pc,           RST_PC);
    check("rst_instr", instr,        32'd0);
    check("rst_mdr",   mdr,          32'd0);
    check("rst_stall", 32'(stall),   32'd0);
    check("rst_err",   32'(mem_err), 32'd0);
    reset = 0;

    // Fetch, ready in first WAIT cycle; PC advances to 4 afterwards.
    do_access(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h4, 32'h0, 32'h8C22_0004, 1);
    check("fetch_op", 32'(op), 32'h23);
    // Slow fetch, ready 5 cycles into WAIT.
    do_access(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h8, 32'h0, 32'h2002_0005, 5);
    // LW data read.
    do_access(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'hDEAD_BEEF, 1);
    // SW with memread also set: write wins, MDR untouched.
    do_access(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 32'h1234_5678, 32'hCAFE_F00D, 2);
    // irwrite and memread together: only IR loads.
    do_access(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0800_0010, 3);

    // PC updates without memory access.
    pc_step(1'b0, 1'b1, 1'b0, 2'b01, 32'h0, 32'h100);          // branch not taken
    pc_step(1'b0, 1'b1, 1'b1, 2'b01, 32'h0, 32'h100);          // branch taken
    check("br_pc", pc, 32'h100);
    pc_step(1'b1, 1'b0, 1'b0, 2'b00, 32'h1000_0000, 32'h0);
    pc_step(1'b1, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0);            // jump
    check("jmp_pc", pc, 32'h1000_0040);
    pc_step(1'b1, 1'b0, 1'b0, 2'b11, 32'h5555_0000, 32'h0);    // hold

`ifdef MEM_TIMEOUT_EN
    // No ready at all: watchdog ends the access, MDR unchanged.
    do_access(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 32'h0000_0055, 0);
    @(posedge clk); #1;
    check("err_sticky", 32'(mem_err), 32'd1);
`endif

    // Reset in the middle of WAIT aborts the access immediately.
    @(posedge clk); #1;
    irwrite = 1; pcwrite = 1; aluresult = 32'h4; mem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_wait_req", 32'(mem_req), 32'd1);
    clear_ctrl();
    reset = 1;
    #1;
    check("abort_req",   32'(mem_req), 32'd0);
    check("abort_pc",    pc,           RST_PC);
    check("abort_instr", instr,        32'd0);
    check("abort_err",   32'(mem_err), 32'd0);
    check("abort_stall", 32'(stall),   32'd0);
    @(posedge clk); #1;
    reset = 0;
    m_pc = RST_PC; m_instr = 0; m_mdr = 0; m_err = 0;
    // Fetch after reset works normally.
    do_access(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h4, 32'h0, 32'h0000_0020, 1);
    check("post_funct", 32'(funct), 32'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_fetch_unit.md
Name: mem_fetch_unit

Overview:
- Multicycle MIPS front end between unified instruction/data memory and the control FSM and datapath.
- Owns PC, instruction register (IR) and memory data register (MDR).
- Runs a request/ready handshake to a variable-latency memory and stalls the control FSM until each access completes.
- Supplies op/funct to the main decoder and applies the decoder's PC-update controls.

Parameters:
- RESET_PC, 32'h0000_0000: PC value after reset.
- TIMEOUT_CYCLES, 255: WAIT-state cycle limit; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- iord  in  1  address select: 0 = PC, 1 = aluout
- irwrite  in  1  fetch: read memory into IR
- memread  in  1  data read: read memory into MDR
- memwrite  in  1  data write of wdata_in
- pcwrite  in  1  unconditional PC update
- branch  in  1  conditional PC update
- zero  in  1  ALU zero flag
- pcsrc  in  2  next-PC select
- aluresult  in  32  combinational ALU result
- aluout  in  32  registered ALU result
- wdata_in  in  32  store data (B register)
- mem_rdata  in  32  memory read data
- mem_ready  in  1  memory completion strobe
- mem_req  out  1  memory request
- mem_we  out  1  write qualifier
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- pc  out  32  program counter
- instr  out  32  IR contents
- op  out  6  instr[31:26]
- funct  out  6  instr[5:0]
- mdr  out  32  MDR contents
- stall  out  1  freeze control FSM/datapath this cycle
- mem_err  out  1  sticky timeout flag; tied 0 without MEM_TIMEOUT_EN

Behaviour:
- Reset state: state = IDLE; pc = RESET_PC; instr = 0; mdr = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; mem_err = 0.
- Reset acts immediately and may abort a pending access; no completion is recorded.
- acc = irwrite | memread | memwrite.
- Access FSM, states IDLE, WAIT, DONE:
  - IDLE with acc=1: register mem_req=1, mem_addr = iord ? aluout : pc, mem_we = memwrite, mem_wdata = wdata_in; go to WAIT.
  - IDLE with acc=0: stay in IDLE.
  - WAIT: mem_req, mem_addr, mem_we and mem_wdata are held stable.
  - WAIT on a rising edge with mem_ready=1: if the access is a read, capture mem_rdata into IR (irwrite) or MDR (memread); clear mem_req and mem_we; go to DONE.
  - DONE: unconditional return to IDLE. A back-to-back access is issued on the following cycle.
- stall = (state==IDLE & acc) | (state==WAIT). stall is combinational. It is 0 in DONE and whenever acc=0.
- Minimum access latency: 2 stall cycles; the control step completes in the DONE cycle.
- mem_ready is ignored in IDLE and DONE.
- Priority:
  - memwrite beats memread and irwrite. A write never updates IR or MDR.
  - irwrite beats memread. Only IR is loaded.
- PC update:
  - pcen = ~stall & (pcwrite | (branch & zero)).
  - Next PC by pcsrc: 00 = aluresult; 01 = aluout; 10 = {pc[31:28], instr[25:0], 2'b00}; 11 = hold, pcen is suppressed.
  - For a fetch, the PC advances in the DONE cycle, i.e. the instruction is latched before the PC changes.
- op and funct are combinational slices of the registered IR.
- Control inputs are assumed stable while stall=1. Any change during WAIT is ignored until DONE.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter runs in WAIT. It reaches TIMEOUT_CYCLES when that many cycles have passed without mem_ready.
  - On timeout: set mem_err (sticky until reset), drop mem_req, go to DONE, leave IR and MDR unchanged.
  - The counter clears whenever WAIT is entered.
- MEM_TIMEOUT_EN undefined:
  - No counter is built. mem_err is constant 0 and WAIT waits indefinitely.

Test Plan:
- Reset, then fetch: irwrite=1, pcwrite=1, pcsrc=00, aluresult=4, mem_ready high in the 1st WAIT cycle, mem_rdata=32'h8C22_0004. Required: stall high for exactly 2 cycles; instr=32'h8C22_0004; op=6'b100011; pc=4 after the DONE cycle; mem_addr=0.
- Slow memory: mem_ready arrives 5 cycles into WAIT. Required: stall high for 6 cycles; mem_addr/mem_we stable throughout; pc changes only after DONE.
- LW data read: iord=1, memread=1, aluout=32'h0000_0040, mem_rdata=32'hDEAD_BEEF. Required: mem_addr=32'h40; mdr=32'hDEAD_BEEF; instr unchanged.
- SW: memwrite=1, memread=1, wdata_in=32'h1234_5678, aluout=32'h80. Required: mem_we=1, mem_wdata=32'h1234_5678, mem_addr=32'h80; mdr unchanged.
- Branch/jump, no access: branch=1, zero=1, pcsrc=01, aluout=32'h100 -> pc=32'h100 next cycle, stall=0. Then pcwrite=1, pcsrc=10, pc=32'h1000_0000, instr[25:0]=26'h10 -> pc=32'h1000_0040. Then pcsrc=11 -> pc holds.
- Reset asserted mid-WAIT -> mem_req=0 and pc=RESET_PC immediately. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, no mem_ready -> mem_err=1 after 8 WAIT cycles, stall drops, IR/MDR unchanged.
